fir_mac: RTL and testbench

Time-multiplexed FIR multiply-accumulate stage sitting directly downstream of the lowpass tap delay line. On each sample strobe it snapshots the L 16-bit taps presented by the delay line and convolves them with L programmable Q1.15 coefficients using one shared multiplier. It then rounds and saturates the sum and emits one 16-bit filtered sample with a valid pulse. It feeds the next channel-strip stage.

---
 rtl/fir_mac.sv | 114 +++++++++++
 tb/tb_fir_mac.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac.sv
// Time-multiplexed FIR MAC: snapshots L taps on a strobe, convolves them with
// L programmable Q1.15 coefficients through one multiplier, rounds and saturates.
module fir_mac #(
  parameter int L     = 5,
  parameter int FRAC  = 15,
  parameter int ACC_W = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [16*L-1:0]        tap_data,
  input  logic                   sample_valid,
  input  logic                   coef_we,
  input  logic [$clog2(L)-1:0]   coef_addr,
  input  logic [15:0]            coef_wdata,
  output logic [15:0]            filt_out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   overrun_clr
);
  localparam int KW = $clog2(L);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(32768);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [L-1:0][15:0]       snap_q, snap_d;
  logic [L-1:0][15:0]       coef_q, coef_d;
  logic [15:0]              filt_q, filt_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  rnd, shr;
  logic [15:0]              sat;

  assign busy      = (state_q != IDLE);
  assign filt_out  = filt_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

  assign prod = $signed(snap_q[k_q]) * $signed(coef_q[k_q]);

  // Round half toward +inf, then arithmetic shift and clamp to 16 bits.
  always_comb begin
    rnd = acc_q + HALF;
    shr = rnd >>> FRAC;
    if (shr > MAXV)      sat = 16'h7FFF;
    else if (shr < MINV) sat = 16'h8000;
    else                 sat = shr[15:0];
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    snap_d      = snap_q;
    coef_d      = coef_q;
    filt_d      = filt_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;

    if (overrun_clr) overrun_d = 1'b0;
    if (sample_valid && busy) overrun_d = 1'b1;

    if (coef_we && !busy && (int'(coef_addr) < L)) coef_d[coef_addr] = coef_wdata;

    case (state_q)
      IDLE: if (sample_valid) begin
        snap_d  = tap_data;
        acc_d   = '0;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W-32){prod[31]}}, prod};
        k_d   = k_q + 1'b1;
        if (k_q == KW'(L - 1)) state_d = OUT;
      end
      OUT: begin
        filt_d      = sat;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      snap_q      <= '0;
      coef_q      <= '0;
      filt_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      snap_q      <= snap_d;
      coef_q      <= coef_d;
      filt_q      <= filt_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end
endmodule

// File: tb/tb_fir_mac.sv
// Scoreboard bench for fir_mac: driver feeds a dot-product reference model that
// queues expected samples; a monitor pops and compares on every out_valid.
module tb_fir_mac;
  localparam int L  = 5;
  localparam int KW = $clog2(L);

  logic               clk = 1'b0;
  logic               reset;
  logic [L-1:0][15:0] taps;
  logic               sample_valid;
  logic               coef_we;
  logic [KW-1:0]      coef_addr;
  logic [15:0]        coef_wdata;
  logic [15:0]        filt_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;
  logic               overrun_clr;

  fir_mac #(.L(L), .FRAC(15), .ACC_W(40)) dut (
    .clk(clk), .reset(reset), .tap_data(taps), .sample_valid(sample_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .filt_out(filt_out), .out_valid(out_valid), .busy(busy),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] v; int t; } exp_t;
  exp_t        q[$];
  int          checks = 0, errors = 0;
  int          edge_n = 0, next_free = 0;
  logic [15:0] m_coef [L];
  logic        m_busy = 1'b0, m_ov = 1'b0;
  logic [15:0] m_last = 16'h0;

  function automatic logic [15:0] ref_fir(input logic [L-1:0][15:0] t);
    longint s = 0, r;
    for (int i = 0; i < L; i++)
      s += longint'($signed(t[i])) * longint'($signed(m_coef[i]));
    r = (s + 16384) >>> 15;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  // Model of what the upcoming rising edge does, given the inputs now applied.
  task automatic model_edge();
    logic b;
    edge_n++;
    if (reset) begin
      foreach (m_coef[i]) m_coef[i] = 16'h0;
      next_free = 0; m_ov = 1'b0; m_last = 16'h0; m_busy = 1'b0;
      q.delete();
      return;
    end
    b = (edge_n < next_free);
    if (overrun_clr) m_ov = 1'b0;
    if (sample_valid && b) m_ov = 1'b1;
    if (coef_we && !b && int'(coef_addr) < L) m_coef[coef_addr] = coef_wdata;
    if (sample_valid && !b) begin
      q.push_back('{ref_fir(taps), edge_n + L + 1});
      next_free = edge_n + L + 2;
    end
    m_busy = (next_free > edge_n + 1);
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic sv, input logic we, input int addr,
                       input logic [15:0] wd, input logic clr, input logic rst);
    sample_valid = sv; coef_we = we; coef_addr = KW'(addr); coef_wdata = wd;
    overrun_clr = clr; reset = rst;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic set_taps(input logic [15:0] v);
    for (int i = 0; i < L; i++) taps[i] = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("overrun", 32'(overrun), 32'(m_ov));
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'(0));
      else begin
        e = q.pop_front();
        chk("filt_out", 32'(filt_out), 32'(e.v));
        chk("out_latency_edge", 32'(edge_n), 32'(e.t));
        m_last = e.v;
      end
    end else if (q.size() > 0 && q[0].t <= edge_n) begin
      chk("missing_out_valid", 32'(out_valid), 32'(1));
      void'(q.pop_front());
    end
    chk("filt_hold", 32'(filt_out), 32'(m_last));
  end

  initial begin
    set_taps(16'h0);
    sample_valid = 0; coef_we = 0; coef_addr = '0; coef_wdata = 16'h0;
    overrun_clr = 0; reset = 1;
    step();
    drive(0, 0, 0, 16'h0, 0, 1);

    // Reset defaults: zero coefficients give zero output.
    set_taps(16'h1234);
    drive(1, 0, 0, 16'h0, 0, 0);
    idle(L + 3);

    // Single-tap gain.
    drive(0, 1, 2, 16'h4000, 0, 0);
    set_taps(16'h7FFF); taps[2] = 16'h1000;
    drive(1, 0, 0, 16'h0, 0, 0);
    idle(L + 2);

    // Saturation both directions.
    for (int i = 0; i < L; i++) drive(0, 1, i, 16'h7FFF, 0, 0);
    set_taps(16'h7FFF);
    drive(1, 0, 0, 16'h0, 0, 0);
    idle(L + 2);
    set_taps(16'h8000);
    drive(1, 0, 0, 16'h0, 0, 0);
    idle(L + 2);

    // Rounding around the half-LSB point.
    for (int i = 0; i < L; i++) drive(0, 1, i, (i == 0) ? 16'h0001 : 16'h0000, 0, 0);
    foreach (taps[i]) taps[i] = 16'h0;
    begin
      logic [15:0] rv [4];
      rv = '{16'h4000, 16'h3FFF, 16'hC000, 16'hBFFF};
      for (int j = 0; j < 4; j++) begin
        taps[0] = rv[j];
        drive(1, 0, 0, 16'h0, 0, 0);
        idle(L + 2);
      end
    end

    // Overrun, coef write while busy, back-to-back strobe with out_valid.
    for (int i = 0; i < L; i++) drive(0, 1, i, 16'($urandom), 0, 0);
    foreach (taps[i]) taps[i] = 16'($urandom);
    drive(1, 0, 0, 16'h0, 0, 0);
    drive(0, 1, 1, 16'h1111, 0, 0);
    drive(1, 0, 0, 16'h0, 0, 0);
    idle(L - 2);
    foreach (taps[i]) taps[i] = 16'($urandom);
    drive(1, 0, 0, 16'h0, 0, 0);
    idle(2);
    drive(0, 0, 0, 16'h0, 1, 0);
    idle(L + 2);
    drive(1, 0, 0, 16'h0, 1, 0);
    drive(1, 0, 0, 16'h0, 1, 0);
    idle(L + 2);

    // Reset mid-MAC aborts the sample and clears coefficients.
    drive(1, 0, 0, 16'h0, 0, 0);
    idle(1);
    drive(0, 0, 0, 16'h0, 0, 1);
    foreach (taps[i]) taps[i] = 16'($urandom);
    drive(1, 0, 0, 16'h0, 0, 0);
    idle(L + 2);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      foreach (taps[i]) taps[i] = 16'($urandom);
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            $urandom_range(0, (1 << KW) - 1), 16'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 150) == 0));
    end
    idle(L + 3);

    chk("scoreboard_drained", 32'(q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
